// File: rtl/counter_nbit_ctrl.sv
// N-bit up/down counter with programmable top value, wrap/saturate modes,
// synchronous clear/load, tick prescaler, terminal-count pulse and compare flag.
module counter_nbit_ctrl #(
    parameter int WIDTH      = 8,
    parameter int MAX_VAL    = 2**WIDTH - 1,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  sync_clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  up_dn,
    input  logic                  sat_mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      cmp_val,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  cmp_match
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  tc_q, tc_d;
    logic                  cmp_match_q;
    logic                  tick;
    logic [WIDTH-1:0]      load_clamped;
    logic                  at_top, at_bottom;

    // >= rather than == so lowering prescale mid-phase cannot skip past the reload point
    assign tick         = (pre_cnt_q >= prescale);
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
    assign at_top       = (count_q == MAX_V);
    assign at_bottom    = (count_q == ZERO);

    always_comb begin
        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
        tc_d      = 1'b0;
        if (sync_clr) begin
            count_d   = ZERO;
            pre_cnt_d = '0;
        end else if (load) begin
            count_d   = load_clamped;
            pre_cnt_d = '0;
        end else if (ena) begin
            if (tick) begin
                pre_cnt_d = '0;
                if (up_dn) begin
                    if (at_top) begin
                        tc_d    = 1'b1;
                        count_d = sat_mode ? MAX_V : ZERO;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end else begin
                    if (at_bottom) begin
                        tc_d    = 1'b1;
                        count_d = sat_mode ? ZERO : MAX_V;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
            end else begin
                pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
            end
        end
    end

    // cmp_match looks at the next count so it lines up with the registered count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= ZERO;
            pre_cnt_q   <= '0;
            tc_q        <= 1'b0;
            cmp_match_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            pre_cnt_q   <= pre_cnt_d;
            tc_q        <= tc_d;
            cmp_match_q <= (count_d == cmp_val);
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign cmp_match = cmp_match_q;

endmodule

// File: tb/tb_counter_nbit_ctrl.sv
// Directed bench for counter_nbit_ctrl: three instances (top 255, 9, 99) share
// one stimulus bus; each vector checks the instance it targets.
module tb_counter_nbit_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, sync_clr, load, up_dn, sat_mode;
    logic [7:0] load_val, cmp_val;
    logic [3:0] prescale;

    logic [7:0] count_f, count_9, count_99;
    logic       tc_f, tc_9, tc_99;
    logic       cm_f, cm_9, cm_99;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    counter_nbit_ctrl #(.WIDTH(8), .MAX_VAL(255), .PRESCALE_W(4)) u_full (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sync_clr(sync_clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .sat_mode(sat_mode), .prescale(prescale),
        .cmp_val(cmp_val), .count(count_f), .tc(tc_f), .cmp_match(cm_f));

    counter_nbit_ctrl #(.WIDTH(8), .MAX_VAL(9), .PRESCALE_W(4)) u_mod9 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sync_clr(sync_clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .sat_mode(sat_mode), .prescale(prescale),
        .cmp_val(cmp_val), .count(count_9), .tc(tc_9), .cmp_match(cm_9));

    counter_nbit_ctrl #(.WIDTH(8), .MAX_VAL(99), .PRESCALE_W(4)) u_mod99 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sync_clr(sync_clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .sat_mode(sat_mode), .prescale(prescale),
        .cmp_val(cmp_val), .count(count_99), .tc(tc_99), .cmp_match(cm_99));

    typedef struct {
        string      name;
        logic       clr;
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic       up;
        logic       sat;
        logic [3:0] ps;
        logic [7:0] cv;
        int         sel;
        logic [7:0] ec;
        logic       et;
        logic       em;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] c, input logic t, input logic m,
                         input logic [7:0] ec, input logic et, input logic em);
        n_checks++;
        if (c === ec && t === et && m === em) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got count=%0d tc=%0b cmp_match=%0b, expected count=%0d tc=%0b cmp_match=%0b",
                     name, c, t, m, ec, et, em);
        end
    endtask

    task automatic drive(input logic clr, input logic ld, input logic [7:0] lv, input logic en,
                         input logic up, input logic sat, input logic [3:0] ps, input logic [7:0] cv);
        sync_clr = clr; load = ld; load_val = lv; ena = en;
        up_dn = up; sat_mode = sat; prescale = ps; cmp_val = cv;
    endtask

    initial begin
        logic [7:0] exp_c;
        logic [7:0] c;
        logic       t, m;

        // Mod-9 down/wrap, compare, and wrap back to top
        vecs.push_back(vec_t'{"m9_load0",   0,1,  0,1,0,0,0,200,1, 0,0,0});
        vecs.push_back(vec_t'{"m9_dn_wrap", 0,0,  0,1,0,0,0,200,1, 9,1,0});
        vecs.push_back(vec_t'{"m9_dn8",     0,0,  0,1,0,0,0,200,1, 8,0,0});
        vecs.push_back(vec_t'{"m9_cmp7",    0,0,  0,1,0,0,0,  7,1, 7,0,1});
        vecs.push_back(vec_t'{"m9_cmp6",    0,0,  0,1,0,0,0,  7,1, 6,0,0});
        vecs.push_back(vec_t'{"m9_dn5",     0,0,  0,1,0,0,0,200,1, 5,0,0});
        vecs.push_back(vec_t'{"m9_dn4",     0,0,  0,1,0,0,0,200,1, 4,0,0});
        vecs.push_back(vec_t'{"m9_dn3",     0,0,  0,1,0,0,0,200,1, 3,0,0});
        vecs.push_back(vec_t'{"m9_dn2",     0,0,  0,1,0,0,0,200,1, 2,0,0});
        vecs.push_back(vec_t'{"m9_dn1",     0,0,  0,1,0,0,0,200,1, 1,0,0});
        vecs.push_back(vec_t'{"m9_dn0",     0,0,  0,1,0,0,0,200,1, 0,0,0});
        vecs.push_back(vec_t'{"m9_rewrap",  0,0,  0,1,0,0,0,200,1, 9,1,0});
        vecs.push_back(vec_t'{"m9_dn8b",    0,0,  0,1,0,0,0,200,1, 8,0,0});
        // Saturation at top, tc re-pulses while held, ena low kills tc
        vecs.push_back(vec_t'{"sat_load8",  0,1,  8,1,1,1,0,200,1, 8,0,0});
        vecs.push_back(vec_t'{"sat_9",      0,0,  0,1,1,1,0,200,1, 9,0,0});
        vecs.push_back(vec_t'{"sat_hold1",  0,0,  0,1,1,1,0,200,1, 9,1,0});
        vecs.push_back(vec_t'{"sat_hold2",  0,0,  0,1,1,1,0,200,1, 9,1,0});
        vecs.push_back(vec_t'{"sat_ena0",   0,0,  0,0,1,1,0,200,1, 9,0,0});
        // Priority, clamp, load/clear independent of ena
        vecs.push_back(vec_t'{"clr_over_ld",1,1,  5,1,1,0,0,200,1, 0,0,0});
        vecs.push_back(vec_t'{"ld_ena0",    0,1,  3,0,1,0,0,200,1, 3,0,0});
        vecs.push_back(vec_t'{"clr_ena0",   1,0,  0,0,1,0,0,200,1, 0,0,0});
        vecs.push_back(vec_t'{"clamp_99",   0,1,200,0,1,0,0, 99,2,99,0,1});
        vecs.push_back(vec_t'{"clamp_9",    0,1,200,0,1,0,0,  9,1, 9,0,1});
        vecs.push_back(vec_t'{"m99_wrap",   0,0,  0,1,1,0,0,  0,2, 0,1,1});
        // Prescaler: tick every 4th enabled edge, phase frozen by ena=0
        vecs.push_back(vec_t'{"ps_load",    0,1,  0,1,1,0,3,200,1, 0,0,0});
        vecs.push_back(vec_t'{"ps_e1",      0,0,  0,1,1,0,3,200,1, 0,0,0});
        vecs.push_back(vec_t'{"ps_e2",      0,0,  0,1,1,0,3,200,1, 0,0,0});
        vecs.push_back(vec_t'{"ps_e3",      0,0,  0,1,1,0,3,200,1, 0,0,0});
        vecs.push_back(vec_t'{"ps_e4",      0,0,  0,1,1,0,3,200,1, 1,0,0});
        vecs.push_back(vec_t'{"ps_e5",      0,0,  0,1,1,0,3,200,1, 1,0,0});
        vecs.push_back(vec_t'{"ps_e6",      0,0,  0,1,1,0,3,200,1, 1,0,0});
        for (int k = 0; k < 5; k++)
            vecs.push_back(vec_t'{"ps_frozen",0,0, 0,0,1,0,3,200,1, 1,0,0});
        vecs.push_back(vec_t'{"ps_e7",      0,0,  0,1,1,0,3,200,1, 1,0,0});
        vecs.push_back(vec_t'{"ps_e8",      0,0,  0,1,1,0,3,200,1, 2,0,0});
        // Lower prescale while pre_cnt=3: tick must come on the next edge
        vecs.push_back(vec_t'{"ps7_load",   0,1,  0,1,1,0,7,200,1, 0,0,0});
        vecs.push_back(vec_t'{"ps7_e1",     0,0,  0,1,1,0,7,200,1, 0,0,0});
        vecs.push_back(vec_t'{"ps7_e2",     0,0,  0,1,1,0,7,200,1, 0,0,0});
        vecs.push_back(vec_t'{"ps7_e3",     0,0,  0,1,1,0,7,200,1, 0,0,0});
        vecs.push_back(vec_t'{"ps_lower",   0,0,  0,1,1,0,1,200,1, 1,0,0});

        // Reset state, with cmp_val=0 to show reset forces cmp_match low
        rst_n = 1'b0;
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset", count_f, tc_f, cm_f, 8'd0, 1'b0, 1'b0);
        cmp_val = 8'd7;
        rst_n   = 1'b1;

        // Free-running full-range count with one wrap
        for (int i = 0; i < 257; i++) begin
            @(posedge clk);
            #1;
            exp_c = 8'((i + 1) % 256);
            check($sformatf("full_cnt_%0d", i), count_f, tc_f, cm_f,
                  exp_c, (i == 255), (exp_c == 8'd7));
        end
        $display("free-run: %0d edges checked", 257);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en,
                  vecs[i].up, vecs[i].sat, vecs[i].ps, vecs[i].cv);
            @(posedge clk);
            #1;
            case (vecs[i].sel)
                0:       begin c = count_f;  t = tc_f;  m = cm_f;  end
                1:       begin c = count_9;  t = tc_9;  m = cm_9;  end
                default: begin c = count_99; t = tc_99; m = cm_99; end
            endcase
            check(vecs[i].name, c, t, m, vecs[i].ec, vecs[i].et, vecs[i].em);
            $display("vec %0d %s: count=%0d tc=%0b cmp_match=%0b", i, vecs[i].name, c, t, m);
        end

        // Async reset between edges at count=42
        drive(0, 1, 42, 0, 1, 0, 0, 42);
        @(posedge clk);
        #1;
        check("pre_async_42", count_f, tc_f, cm_f, 8'd42, 1'b0, 1'b1);
        drive(0, 0, 0, 0, 1, 0, 0, 42);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", count_f, tc_f, cm_f, 8'd0, 1'b0, 1'b0);
        $display("async reset at t=%0t: count=%0d tc=%0b cmp_match=%0b", $time, count_f, tc_f, cm_f);
        @(posedge clk);
        #1;
        check("reset_held", count_f, tc_f, cm_f, 8'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
